alu_rs: RTL

Reservation station for the integer ALU. Holds dispatched ALU/branch/jump micro-ops until both source operands are available, snoops the common data bus (CDB) for pending results, and issues at most one ready micro-op per cycle, as registered outputs, to the combinational `alu` stage. It sits between the dispatch/rename stage and `alu`. The ALU result returns to this block over the CDB.

---
 rtl/alu_rs.sv | 136 +++++++++++++
 1 files changed

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: holds dispatched micro-ops until
// both operands are valid, snoops the CDB, and issues one ready op per cycle.
module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int OP_W    = 6,
  parameter int XLEN    = 32,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_ena,
  input  logic [OP_W-1:0]  in_op,
  input  logic [XLEN-1:0]  in_A,
  input  logic [XLEN-1:0]  in_B,
  input  logic             in_A_ready,
  input  logic             in_B_ready,
  input  logic [TAG_W-1:0] in_A_tag,
  input  logic [TAG_W-1:0] in_B_tag,
  input  logic [TAG_W-1:0] in_rob_tag,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  output logic             rs_full,
  output logic             alu_ena,
  output logic [OP_W-1:0]  alu_op,
  output logic [XLEN-1:0]  alu_A,
  output logic [XLEN-1:0]  alu_B,
  output logic [TAG_W-1:0] alu_rob_tag,
  output logic [XLEN-1:0]  alu_pc,
  output logic [XLEN-1:0]  alu_imm
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] rj;
  logic [RS_SIZE-1:0] rk;
  logic [RS_SIZE-1:0] ready;
  logic [OP_W-1:0]    op_q  [RS_SIZE];
  logic [XLEN-1:0]    vj    [RS_SIZE];
  logic [XLEN-1:0]    vk    [RS_SIZE];
  logic [TAG_W-1:0]   qj    [RS_SIZE];
  logic [TAG_W-1:0]   qk    [RS_SIZE];
  logic [TAG_W-1:0]   rob_q [RS_SIZE];
  logic [XLEN-1:0]    pc_q  [RS_SIZE];
  logic [XLEN-1:0]    imm_q [RS_SIZE];

  logic             sel_vld;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] free_idx;
  logic             a_byp;
  logic             b_byp;

  assign ready   = busy & rj & rk;
  assign rs_full = &busy;

  // Scanning from the top down leaves the lowest matching index in place.
  always_comb begin
    sel_vld  = |ready;
    sel_idx  = '0;
    free_idx = '0;
    for (int unsigned i = RS_SIZE; i > 0; i--) begin
      if (ready[i-1]) sel_idx = IDX_W'(i - 1);
      if (!busy[i-1]) free_idx = IDX_W'(i - 1);
    end
    a_byp = cdb_valid && !in_A_ready && (cdb_tag == in_A_tag);
    b_byp = cdb_valid && !in_B_ready && (cdb_tag == in_B_tag);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= '0;
      rj          <= '0;
      rk          <= '0;
      alu_ena     <= 1'b0;
      alu_op      <= '0;
      alu_A       <= '0;
      alu_B       <= '0;
      alu_rob_tag <= '0;
      alu_pc      <= '0;
      alu_imm     <= '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        op_q[i]  <= '0;
        vj[i]    <= '0;
        vk[i]    <= '0;
        qj[i]    <= '0;
        qk[i]    <= '0;
        rob_q[i] <= '0;
        pc_q[i]  <= '0;
        imm_q[i] <= '0;
      end
    end else if (flush) begin
      busy    <= '0;
      alu_ena <= 1'b0;
    end else begin
      alu_ena <= sel_vld;
      if (sel_vld) begin
        alu_op        <= op_q[sel_idx];
        alu_A         <= vj[sel_idx];
        alu_B         <= vk[sel_idx];
        alu_rob_tag   <= rob_q[sel_idx];
        alu_pc        <= pc_q[sel_idx];
        alu_imm       <= imm_q[sel_idx];
        busy[sel_idx] <= 1'b0;
      end
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && cdb_valid && !rj[i] && (qj[i] == cdb_tag)) begin
          vj[i] <= cdb_data;
          rj[i] <= 1'b1;
        end
        if (busy[i] && cdb_valid && !rk[i] && (qk[i] == cdb_tag)) begin
          vk[i] <= cdb_data;
          rk[i] <= 1'b1;
        end
      end
      // The free slot is never busy, so it cannot collide with wakeup or issue.
      if (in_ena && !rs_full) begin
        busy[free_idx]  <= 1'b1;
        op_q[free_idx]  <= in_op;
        vj[free_idx]    <= a_byp ? cdb_data : in_A;
        vk[free_idx]    <= b_byp ? cdb_data : in_B;
        rj[free_idx]    <= in_A_ready | a_byp;
        rk[free_idx]    <= in_B_ready | b_byp;
        qj[free_idx]    <= in_A_tag;
        qk[free_idx]    <= in_B_tag;
        rob_q[free_idx] <= in_rob_tag;
        pc_q[free_idx]  <= in_pc;
        imm_q[free_idx] <= in_imm;
      end
    end
  end

endmodule
